// File: rtl/seq_div_32.sv
// seq_div_32: multi-cycle shift-and-subtract integer divider.
// Produces one quotient bit per clock, then applies the result signs in a
// final cycle. Supports signed (truncating) and unsigned division, and
// flags divide-by-zero with a fixed result pattern.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DONE,
    output logic             BUSY,
    output logic             DBZ
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
    logic [WIDTH-1:0] a_q, a_d;         // original dividend, returned as R on divide-by-zero
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dbzf_q, dbzf_d;   // divide-by-zero detected at acceptance
    logic             dbz_q, dbz_d;     // registered DBZ output
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Working values for the current iteration
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, trial;

    // Next-state and datapath: operand capture, one trial subtraction per RUN cycle, sign fix-up
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        a_d     = a_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbzf_d  = dbzf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        a_mag  = (SIGNED && A[WIDTH-1]) ? -A : A;
        b_mag  = (SIGNED && B[WIDTH-1]) ? -B : B;
        // The remainder is kept one bit wider than the operands so the
        // shifted value never loses its top bit before the subtraction.
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d    = A;
                    dvd_d  = a_mag;
                    dsr_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    negq_d = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                    negr_d = SIGNED & A[WIDTH-1];
                    dbzf_d = (B == '0);
                    busy_d = 1'b1;
                    state_d = (B == '0) ? SIGN : RUN;
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (dbzf_q) begin
                    q_d   = '1;
                    r_d   = a_q;
                    dbz_d = 1'b1;
                end else begin
                    q_d   = negq_q ? -dvd_q : dvd_q;
                    r_d   = negr_q ? -rem_q : rem_q;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbzf_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            a_q     <= a_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbzf_q  <= dbzf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign DBZ  = dbz_q;
    assign DONE = done_q;
    assign BUSY = busy_q;

endmodule
